// File: rtl/rf_wb_ctrl_pkg.sv
// Shared sizing defaults and helpers for the register-file write-back controller.
// Defaults mirror the core-wide register-file geometry used by the execution units.
package rf_wb_ctrl_pkg;

    localparam int RF_SIZE_LOG_DEF = 5;
    localparam int REG_LEN_DEF     = 32;
    localparam int RF_SIZE_DEF     = 1 << RF_SIZE_LOG_DEF;
    localparam int WB_NUM_DEF      = 2;

    // Next round-robin position after requester g wins, wrapping at n.
    function automatic int rr_next(input int g, input int n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/rf_wb_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr (modulo NUM_WB) wins.
// The pointer itself is owned and updated by the instantiating block.
module rr_arbiter #(
    parameter int NUM_WB = 2,
    parameter int PTR_W  = (NUM_WB > 1) ? $clog2(NUM_WB) : 1
) (
    input  logic [NUM_WB-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_WB-1:0] grant,
    output logic [PTR_W-1:0]  win
);

    always_comb begin
        logic found;
        int   idx;
        grant = '0;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_WB; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_WB) begin
                idx = idx - NUM_WB;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win        = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Write-back controller: arbitrates requesters onto the single register-file write port,
// registers the winning write, and tracks outstanding destination writes in a busy scoreboard.
module rf_wb_ctrl
    import rf_wb_ctrl_pkg::*;
#(
    parameter int NUM_WB      = WB_NUM_DEF,
    parameter int RF_SIZE_LOG = RF_SIZE_LOG_DEF,
    parameter int REG_LEN     = REG_LEN_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_WB-1:0]             wb_valid,
    input  logic [NUM_WB*RF_SIZE_LOG-1:0] wb_rd,
    input  logic [NUM_WB*REG_LEN-1:0]     wb_data,
    output logic [NUM_WB-1:0]             wb_ready,
    input  logic                          alloc_valid,
    input  logic [RF_SIZE_LOG-1:0]        alloc_rd,
    output logic                          alloc_ready,
    output logic [(2**RF_SIZE_LOG)-1:0]   busy,
    output logic                          rf_wen,
    output logic [RF_SIZE_LOG-1:0]        rf_rd,
    output logic [REG_LEN-1:0]            rf_rd_data
);

    localparam int PTR_W = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;
    localparam int NREGS = 2 ** RF_SIZE_LOG;

    logic [PTR_W-1:0]       r_ptr;
    logic [NREGS-1:0]       r_busy;
    logic                   r_rf_wen;
    logic [RF_SIZE_LOG-1:0] r_rf_rd;
    logic [REG_LEN-1:0]     r_rf_rd_data;

    logic [NUM_WB-1:0]      w_req;
    logic [NUM_WB-1:0]      w_grant;
    logic [PTR_W-1:0]       w_win;
    logic                   w_fire;
    logic                   w_alloc_fire;
    logic [PTR_W-1:0]       w_ptr_next;
    logic [NREGS-1:0]       w_busy_next;
    logic [RF_SIZE_LOG-1:0] w_rd_arr   [NUM_WB];
    logic [REG_LEN-1:0]     w_data_arr [NUM_WB];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WB; gi++) begin : g_unpack
            assign w_rd_arr[gi]   = wb_rd[gi*RF_SIZE_LOG +: RF_SIZE_LOG];
            assign w_data_arr[gi] = wb_data[gi*REG_LEN +: REG_LEN];
        end
    endgenerate

    // Masking requests during reset keeps every grant, and thus every handshake, at zero.
    assign w_req = wb_valid & {NUM_WB{~rst}};

    rr_arbiter #(
        .NUM_WB (NUM_WB),
        .PTR_W  (PTR_W)
    ) u_arb (
        .req   (w_req),
        .ptr   (r_ptr),
        .grant (w_grant),
        .win   (w_win)
    );

    assign wb_ready     = w_grant;
    assign w_fire       = |w_grant;
    assign alloc_ready  = ~r_busy[alloc_rd] & ~rst;
    assign w_alloc_fire = alloc_valid & alloc_ready;
    assign w_ptr_next   = PTR_W'(rr_next(int'(w_win), NUM_WB));

    // Clear of the register being written and set of a new reservation may hit different bits.
    always_comb begin
        w_busy_next = r_busy;
        if (r_rf_wen) begin
            w_busy_next[r_rf_rd] = 1'b0;
        end
        if (w_alloc_fire) begin
            w_busy_next[alloc_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr        <= '0;
            r_busy       <= '0;
            r_rf_wen     <= 1'b0;
            r_rf_rd      <= '0;
            r_rf_rd_data <= '0;
        end else begin
            r_busy <= w_busy_next;
            if (w_fire) begin
                r_ptr        <= w_ptr_next;
                r_rf_wen     <= 1'b1;
                r_rf_rd      <= w_rd_arr[w_win];
                r_rf_rd_data <= w_data_arr[w_win];
            end else begin
                r_rf_wen <= 1'b0;
            end
        end
    end

    assign busy       = r_busy;
    assign rf_wen     = r_rf_wen;
    assign rf_rd      = r_rf_rd;
    assign rf_rd_data = r_rf_rd_data;

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Directed and random stimulus for rf_wb_ctrl, checked every cycle against a
// transaction-level model of arbitration, the write stage and the busy scoreboard.
module tb_rf_wb_ctrl;

    localparam int NW  = 2;
    localparam int RL  = 5;
    localparam int DL  = 32;
    localparam int NR  = 1 << RL;

    logic              clk = 1'b0;
    logic              rst;
    logic [NW-1:0]     wb_valid;
    logic [NW*RL-1:0]  wb_rd;
    logic [NW*DL-1:0]  wb_data;
    logic [NW-1:0]     wb_ready;
    logic              alloc_valid;
    logic [RL-1:0]     alloc_rd;
    logic              alloc_ready;
    logic [NR-1:0]     busy;
    logic              rf_wen;
    logic [RL-1:0]     rf_rd;
    logic [DL-1:0]     rf_rd_data;

    int total = 0;
    int bad   = 0;

    // Model state: who is next in line, which registers have a pending write, and
    // the write currently presented to the register file.
    int            m_next;
    logic [NR-1:0] m_busy;
    logic          m_wen;
    logic [RL-1:0] m_rd;
    logic [DL-1:0] m_data;
    logic          m_known = 1'b0;

    always #5 clk = ~clk;

    rf_wb_ctrl #(
        .NUM_WB      (NW),
        .RF_SIZE_LOG (RL),
        .REG_LEN     (DL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .wb_ready    (wb_ready),
        .alloc_valid (alloc_valid),
        .alloc_rd    (alloc_rd),
        .alloc_ready (alloc_ready),
        .busy        (busy),
        .rf_wen      (rf_wen),
        .rf_rd       (rf_rd),
        .rf_rd_data  (rf_rd_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model at the edge.
    task automatic cyc(input logic r, input logic [1:0] v,
                       input logic [RL-1:0] rd0, input logic [RL-1:0] rd1,
                       input logic [DL-1:0] d0, input logic [DL-1:0] d1,
                       input logic av, input logic [RL-1:0] ar);
        logic [RL-1:0] rds [NW];
        logic [DL-1:0] ds  [NW];
        logic [NW-1:0] exp_rdy;
        int            g;
        logic          exp_ardy;
        @(negedge clk);
        rst         = r;
        wb_valid    = v;
        wb_rd       = {rd1, rd0};
        wb_data     = {d1, d0};
        alloc_valid = av;
        alloc_rd    = ar;
        rds[0] = rd0; rds[1] = rd1;
        ds[0]  = d0;  ds[1]  = d1;
        #1;
        exp_rdy = '0;
        g       = -1;
        if (!r) begin
            for (int k = 0; k < NW; k++) begin
                int i;
                i = (m_next + k) % NW;
                if (g < 0 && v[i]) g = i;
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
        end
        exp_ardy = !r && (!m_known || !m_busy[ar]);
        chk("wb_ready", 64'(wb_ready), 64'(exp_rdy));
        if (m_known || r) chk("alloc_ready", 64'(alloc_ready), 64'(exp_ardy));
        if (m_known) begin
            chk("busy", 64'(busy), 64'(m_busy));
            chk("rf_wen", 64'(rf_wen), 64'(m_wen));
            chk("rf_rd", 64'(rf_rd), 64'(m_rd));
            chk("rf_rd_data", 64'(rf_rd_data), 64'(m_data));
        end
        @(posedge clk);
        if (r) begin
            m_next  = 0;
            m_busy  = '0;
            m_wen   = 1'b0;
            m_rd    = '0;
            m_data  = '0;
            m_known = 1'b1;
        end else begin
            if (m_wen) m_busy[m_rd] = 1'b0;
            if (av && exp_ardy) m_busy[ar] = 1'b1;
            if (g >= 0) begin
                m_next = (g + 1) % NW;
                m_wen  = 1'b1;
                m_rd   = rds[g];
                m_data = ds[g];
            end else begin
                m_wen = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1; wb_valid = '0; wb_rd = '0; wb_data = '0;
        alloc_valid = 1'b0; alloc_rd = '0;

        // Reset with requests pending: nothing may be granted.
        cyc(1, 2'b11, 1, 2, 32'hA, 32'hB, 1, 3);
        // Fairness: both valid for four cycles, grants alternate starting at 0.
        repeat (4) cyc(0, 2'b11, 1, 2, 32'hA, 32'hB, 0, 0);
        cyc(0, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("fair_last_rd", 64'(rf_rd), 64'd2);
        // Scoreboard: reserve 3, retry (stalls), write back 3, watch it clear.
        cyc(0, 2'b00, 0, 0, 0, 0, 1, 3);
        cyc(0, 2'b00, 0, 0, 0, 0, 1, 3);
        cyc(0, 2'b01, 3, 0, 32'h33, 0, 1, 3);
        cyc(0, 2'b00, 0, 0, 0, 0, 1, 3);
        cyc(0, 2'b00, 0, 0, 0, 0, 0, 3);
        chk("sb_busy3_clear", 64'(busy[3]), 64'd0);
        // Simultaneous clear of 2 and reservation of 1.
        cyc(0, 2'b00, 0, 0, 0, 0, 1, 2);
        cyc(0, 2'b10, 0, 2, 0, 32'h22, 0, 0);
        cyc(0, 2'b00, 0, 0, 0, 0, 1, 1);
        cyc(0, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("sim_busy_pair", 64'(busy[2:1]), 64'b01);
        // Reset right after a fire drops the pending write and the reservations.
        cyc(0, 2'b01, 7, 0, 32'h77, 0, 1, 9);
        cyc(1, 2'b00, 0, 0, 0, 0, 0, 0);
        cyc(0, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("midrst_wen", 64'(rf_wen), 64'd0);
        // Only requester 1: granted every cycle with no bubbles.
        repeat (3) cyc(0, 2'b10, 0, 5, 0, 32'h55, 0, 0);
        cyc(0, 2'b00, 0, 0, 0, 0, 0, 0);
        // Random traffic over a small register window to provoke busy collisions.
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 39) == 0),
                2'($urandom_range(0, 3)),
                RL'($urandom_range(0, 7)), RL'($urandom_range(0, 7)),
                $urandom, $urandom,
                1'($urandom_range(0, 1)), RL'($urandom_range(0, 7)));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_wb_ctrl.md
# rf_wb_ctrl

Write-back controller for the out-of-order core's register file. It round-robin arbitrates several write-back requesters onto the register file's single write port and registers the winning write. It also keeps a per-register busy scoreboard that issue logic sets on allocation and write-back clears. It sits between the execution units and the register file's write port (wen/rd/rd_data).

## Interface

Parameters:
- NUM_WB, default 2: number of write-back requesters (2..4).
- RF_SIZE_LOG, default `RF_SIZE_LOG: register index width.
- REG_LEN, default `REG_LEN: data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; one clock, synchronous, active-high.
- wb_valid  in  NUM_WB  per-requester write-back request.
- wb_rd  in  NUM_WB*RF_SIZE_LOG  destination index; requester i in slice i.
- wb_data  in  NUM_WB*REG_LEN  write data; requester i in slice i.
- wb_ready  out  NUM_WB  grant, one-hot or zero, combinational.
- alloc_valid  in  1  issue reserves a destination register.
- alloc_rd  in  RF_SIZE_LOG  register being reserved.
- alloc_ready  out  1  reservation accepted, combinational.
- busy  out  2**RF_SIZE_LOG  scoreboard; bit r set means a write to r is outstanding.
- rf_wen  out  1  to the register file's wen.
- rf_rd  out  RF_SIZE_LOG  to the register file's rd.
- rf_rd_data  out  REG_LEN  to the register file's rd_data.

## Operation

- **Arbitration.**
  - Round-robin pointer ptr, log2(NUM_WB) bits.
  - The grant goes to the first i with wb_valid[i], searching ptr, ptr+1, … modulo NUM_WB.
  - wb_ready[i] is 1 only for the granted i. A fire is wb_valid[i] & wb_ready[i]. At most one fire per cycle.
  - On a fire by requester g: ptr <= (g+1) mod NUM_WB. With no fire, ptr holds.
  - wb_ready does not depend on the register file; the write port never back-pressures.
- **Write stage.**
  - On a fire: rf_wen <= 1; rf_rd <= wb_rd[g]; rf_rd_data <= wb_data[g].
  - With no fire: rf_wen <= 0. rf_rd and rf_rd_data hold their previous values.
- **Scoreboard.**
  - busy[r] is set on an alloc handshake (alloc_valid & alloc_ready) with alloc_rd = r.
  - busy[r] is cleared on the edge where rf_wen = 1 and rf_rd = r. This is the same edge the register file writes r.
  - alloc_ready = ~busy[alloc_rd] & ~rst. A WAW re-allocation stalls until the prior write lands.
  - If rf_wen clears r and an alloc of a different r' happens in the same cycle, both updates apply.
  - The same-r set/clear case cannot occur, because alloc is blocked while busy[r] = 1.
  - A write-back to a non-busy register is still written. busy is unchanged.
- **Reset.**
  - Values after reset: ptr = 0, busy = 0, rf_wen = 0, rf_rd = 0, rf_rd_data = 0.
  - While rst = 1: wb_ready = 0 and alloc_ready = 0. No handshakes occur during reset.
  - Reset mid-operation drops any pending write in the write stage; it does not reach the register file. All reservations are discarded.

## Timing

- Write-back fire in cycle t: rf_wen = 1 during cycle t+1. The register file array updates at the end of t+1, and busy[rd] reads 0 from cycle t+2.
- Alloc in cycle t: busy[rd] = 1 from cycle t+1.
- Back-to-back fires are sustained: one write per cycle, with ptr rotating every cycle.
- wb_ready and alloc_ready are combinational from registered state and same-cycle valid and index inputs only. There is no path from rf_* to ready.

## Structure

- `RF_SIZE_LOG, `REG_LEN and `RF_SIZE come from the shared OOO_v1/param.v include. Add `WB_NUM there as the NUM_WB default.
- One natural sub-module is `rr_arbiter`: parameterised NUM_WB, with inputs req and ptr, output one-hot grant, and the encoded winner index. It is purely combinational. The pointer register stays in rf_wb_ctrl.
- The scoreboard and write stage are inline.

## Test plan

- **Reset.** Assert rst for 1 cycle with wb_valid = 2'b11 and alloc_valid = 1. Expected: wb_ready = 0, alloc_ready = 0, rf_wen = 0, busy = 0. In the next cycle the grant goes to requester 0 (ptr = 0).
- **Fairness.** Hold wb_valid = 2'b11 for 4 cycles, with rd 1/2 and data 0xA/0xB. Expected: grants alternate 0,1,0,1; rf_wen = 1 in cycles 2..5 with rf_rd 1,2,1,2.
- **Scoreboard.** alloc rd = 3 in cycle 0: busy[3] = 1 at cycle 1. Alloc rd = 3 again: alloc_ready = 0. Write-back rd = 3 fires in cycle 2: rf_wen at cycle 3, busy[3] = 0 and alloc_ready = 1 at cycle 4.
- **Simultaneous events.** With busy[2] = 1, rf_wen writes rd = 2 in the same cycle as alloc rd = 1. Expected next cycle: busy[1] = 1, busy[2] = 0.
- **Reset mid-operation.** A fire occurs in cycle t and rst is asserted in cycle t+1. Expected: rf_wen = 0 in t+2, busy all 0, ptr = 0.
- **Single requester.** Only requester 1 is valid for 3 cycles. Expected: granted every cycle, ptr stays at 0 after each fire, no idle bubbles.
